// File: rtl/uart_tx_frame_gen_pkg.sv
// Shared UART definitions: TX frame state encoding, parity type encoding and line levels.
// The parity encoding is also used by the RX parity checker.
package uart_tx_frame_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

endpackage

// File: rtl/uart_tx_serializer.sv
// Data shift register and bit counter for the UART transmitter.
// Loads a byte on acceptance, shifts right on enable, flags the last data bit.
module uart_tx_serializer #(
  parameter int DATA_WIDTH    = 8,
  parameter int COUNTER_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  shift_i,
  input  logic                  count_i,
  output logic                  bit_o,
  output logic                  done_o
);

  localparam logic [COUNTER_WIDTH-1:0] LAST_CNT = COUNTER_WIDTH'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0]    shift_q, shift_d;
  logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      shift_d = data_i;
      cnt_d   = '0;
    end else begin
      if (shift_i) begin
        shift_d = shift_q >> 1;
      end
      // Counter clears on the last data bit so it never exceeds DATA_WIDTH-1.
      if (count_i) begin
        cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + COUNTER_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bit_o  = shift_q[0];
  assign done_o = (cnt_q == LAST_CNT);

endmodule

// File: rtl/uart_tx_frame_gen.sv
// UART transmit frame generator: start bit, LSB-first data, optional parity, stop bit.
// One frame bit per baud clock; TX_OUT and Busy are registered from the next-state decode.
module uart_tx_frame_gen
  import uart_tx_frame_gen_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int COUNTER_WIDTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  Busy
);

  function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] data, input logic typ);
    calc_parity = (^data) ^ (typ == PAR_ODD);
  endfunction

  tx_state_e state_q, state_d;
  logic      tx_q, tx_d;
  logic      busy_q, busy_d;
  logic      par_en_q, par_bit_q;

  logic load, shift_en, count_en;
  logic ser_bit, ser_done;

  uart_tx_serializer #(
    .DATA_WIDTH   (DATA_WIDTH),
    .COUNTER_WIDTH(COUNTER_WIDTH)
  ) u_ser (
    .clk_i  (CLK),
    .rst_i  (RST),
    .load_i (load),
    .data_i (P_DATA),
    .shift_i(shift_en),
    .count_i(count_en),
    .bit_o  (ser_bit),
    .done_o (ser_done)
  );

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    shift_en = 1'b0;
    count_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Data_Valid) begin
          state_d = ST_START;
          load    = 1'b1;
        end
      end
      // The serializer runs one bit ahead of the line because TX_OUT is registered.
      ST_START: begin
        state_d  = ST_DATA;
        shift_en = 1'b1;
      end
      ST_DATA: begin
        shift_en = 1'b1;
        count_en = 1'b1;
        if (ser_done) begin
          state_d = par_en_q ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: state_d = ST_STOP;
      ST_STOP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_d   = LINE_IDLE;
    busy_d = (state_d != ST_IDLE);
    case (state_d)
      ST_START:  tx_d = LINE_START;
      ST_DATA:   tx_d = ser_bit;
      ST_PARITY: tx_d = par_bit_q;
      default:   tx_d = LINE_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      tx_q      <= LINE_IDLE;
      busy_q    <= 1'b0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      if (load) begin
        par_en_q  <= PAR_EN;
        par_bit_q <= calc_parity(P_DATA, PAR_TYP);
      end
    end
  end

  assign TX_OUT = tx_q;
  assign Busy   = busy_q;

endmodule

// File: doc/uart_tx_frame_gen.md
Name: uart_tx_frame_gen

Overview:
UART transmitter that converts a parallel byte plus a valid strobe into a serial frame: start bit, data bits LSB first, an optional parity bit and a stop bit. It runs on the TX baud clock, so every frame bit lasts exactly one CLK cycle. It is the transmit-side counterpart of the oversampling UART RX path and sits in the UART top, driven by the TX FIFO/sync logic. Parity settings match the RX configuration register encoding.

Parameters:
DATA_WIDTH, 8, number of data bits per frame.
COUNTER_WIDTH, 4, data-bit counter width; must satisfy 2^COUNTER_WIDTH > DATA_WIDTH.

Ports:
CLK  input  1  TX baud clock; one frame bit per cycle.
RST  input  1  reset; synchronous, active-high.
P_DATA  input  DATA_WIDTH  byte to transmit; sampled only at acceptance.
Data_Valid  input  1  request to send P_DATA.
PAR_EN  input  1  1 = insert a parity bit; sampled at acceptance.
PAR_TYP  input  1  0 = even parity, 1 = odd parity; sampled at acceptance.
TX_OUT  output  1  serial line, registered; idles high.
Busy  output  1  registered; high from the start bit through the stop bit.

Behaviour:
- Reset (RST=1 at a CLK edge) forces the following values: state IDLE, TX_OUT=1, Busy=0, shift register 0, bit counter 0, latched parity config 0.
- Reset mid-frame abandons the frame. From the next cycle: TX_OUT=1 and Busy=0. No stop bit is completed.
- States:
  - IDLE: TX_OUT=1, Busy=0.
  - START: TX_OUT=0.
  - DATA: DATA_WIDTH cycles.
  - PARITY: 1 cycle, only if the latched PAR_EN=1.
  - STOP: TX_OUT=1.
  - Busy=1 in START, DATA, PARITY and STOP.
- Acceptance happens only at an edge where state=IDLE and Data_Valid=1. At that edge the block latches P_DATA, PAR_EN, PAR_TYP and the computed parity bit.
- Data_Valid while Busy=1 is ignored. The byte is dropped and the upstream logic must hold the request.
- Latency: the start bit appears on TX_OUT in the cycle right after the acceptance edge.
- Transitions:
  - IDLE to START on acceptance.
  - START to DATA.
  - DATA to PARITY or STOP after DATA_WIDTH bits. The counter runs 0..DATA_WIDTH-1; the transition happens at count DATA_WIDTH-1.
  - PARITY to STOP.
  - STOP to IDLE, unconditionally.
- Data order: LSB first. In data cycle k, TX_OUT = P_DATA[k] as latched.
- Parity: even = XOR of all data bits; odd = the inverse of that. It is computed from the latched data.
- Frame length is DATA_WIDTH+3 cycles with parity and DATA_WIDTH+2 without (11 and 10 at the default width).
- Back-to-back frames: Data_Valid held high gives exactly one IDLE cycle (TX_OUT=1, Busy=0) between stop bit and next start bit, which is an extra stop-length gap. This is intended.
- Changes on P_DATA, PAR_EN or PAR_TYP mid-frame do not affect the frame in progress.
- Counter wrap: the bit counter clears on leaving DATA and never exceeds DATA_WIDTH-1.
- TX_OUT is driven from a flop with no combinational path from the inputs, so the line is glitch-free.

Decomposition:
- Shared UART package holds:
  - the state encoding constants (IDLE, START, DATA, PARITY, STOP; 3-bit);
  - the PAR_TYP encoding constants (EVEN=0, ODD=1), shared with RX parity check;
  - the idle/stop line level constant (1).
- One sub-module is natural: uart_tx_serializer. It holds the shift register and bit counter, loads on acceptance, shifts on enable, and flags done at the last bit.
- The FSM, parity calculation and output mux stay in the top module.

Test Plan:
- P_DATA=0xA5, PAR_EN=0, single Data_Valid pulse in IDLE -> next cycle TX_OUT sequence 0,1,0,1,0,0,1,0,1,1; Busy=1 for exactly 10 cycles, then TX_OUT=1 and Busy=0.
- P_DATA=0xA5 (four ones), PAR_EN=1: PAR_TYP=0 -> parity bit 0; PAR_TYP=1 -> parity bit 1; Busy high 11 cycles. Repeat with 0x07 (three ones): even -> 1, odd -> 0.
- Data_Valid held high with 0x55 then 0x0F -> two complete frames separated by exactly one cycle with TX_OUT=1 and Busy=0; the second frame carries 0x0F.
- Pulse Data_Valid with 0xFF while sending 0x00, and toggle PAR_EN/PAR_TYP mid-frame -> current frame unchanged (all-zero data, original parity setting); 0xFF is never transmitted.
- Assert RST for one cycle during data bit 3 -> next cycle TX_OUT=1, Busy=0, state IDLE; a new Data_Valid two cycles later starts a clean frame with the correct start bit.
- RST held, Data_Valid=1 -> TX_OUT stays 1 and Busy stays 0 throughout; the first frame starts one cycle after RST is released, when the first acceptance edge occurs.
